psum_accum_engine: RTL
======================

PSUM_ACCUM_ENGINE -- requirements
Module: psum_accum_engine

Interface
REQ-001 SHALL have parameter col, default 8, lane count per psum vector.
REQ-002 SHALL have parameter psum_bw, default 16, signed two's-complement width per lane.
REQ-003 SHALL have parameter addr_bw, default 11, psum memory address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  job launch pulse; sampled only in IDLE.
REQ-007 SHALL have port acc_mode  input  1  0 = overwrite, 1 = read-add-write; latched at start.
REQ-008 SHALL have port relu_en  input  1  clamp negative lanes to 0 before write; latched at start.
REQ-009 SHALL have port base_addr  input  addr_bw  first psum address; latched at start.
REQ-010 SHALL have port len  input  addr_bw+1  vector count; latched at start.
REQ-011 SHALL have port ofifo_valid  input  1  OFIFO holds at least one vector.
REQ-012 SHALL have port ofifo_out  input  col*psum_bw  OFIFO head vector, lane 0 in LSBs.
REQ-013 SHALL have port ofifo_rd  output  1  pop OFIFO head this cycle.
REQ-014 SHALL have ports CEN, WEN  output  1 each  psum SRAM enables, active-low.
REQ-015 SHALL have ports A  output  addr_bw, D  output  col*psum_bw  SRAM address and write data.
REQ-016 SHALL have port Q  input  col*psum_bw  SRAM read data, valid the cycle after a read.
REQ-017 SHALL have ports busy, done  output  1 each  job in progress; one-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, WRITE, DONE.
REQ-019 IDLE: start=1 latches job fields, sets addr=base_addr, remaining=len; next FETCH if len!=0, else DONE.
REQ-020 FETCH: ofifo_valid=0 -> hold, no SRAM access; ofifo_valid=1 -> ofifo_rd=1 for exactly that cycle, ofifo_out captured into data register, next WRITE.
REQ-021 FETCH with ofifo_valid=1 and acc_mode=1 SHALL issue a read in the same cycle: CEN=0, WEN=1, A=addr.
REQ-022 WRITE: CEN=0, WEN=0, A=addr, D=f(captured) for acc_mode=0 or f(captured+Q) for acc_mode=1, lanes independent.
REQ-023 f SHALL apply ReLU per lane when relu_en=1 (negative lane -> 0), else identity.
REQ-024 After WRITE, addr increments modulo 2^addr_bw and remaining decrements; next FETCH if remaining!=0, else DONE.
REQ-025 DONE: done=1 for one cycle, next IDLE.
REQ-026 busy SHALL be 1 in FETCH and WRITE, 0 in IDLE and DONE.
REQ-027 Outside the accesses of REQ-021/022: CEN=1, WEN=1, D=0, A=addr; ofifo_rd=0 outside FETCH.
REQ-028 start while not in IDLE SHALL be ignored; job inputs may change freely after the start cycle.
REQ-029 Throughput SHALL be 2 cycles per vector with ofifo_valid continuously 1, in both modes.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, addr=0, remaining=0, data register=0, overriding start and any in-flight job.
REQ-031 During and after reset: ofifo_rd=0, CEN=1, WEN=1, A=0, D=0, busy=0, done=0; an aborted job issues no further access.

Configuration
REQ-032 Macro PSUM_SAT_EN defined: per-lane add saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-033 PSUM_SAT_EN undefined: per-lane add wraps modulo 2^psum_bw; ReLU applied after add in both builds.

Verification
REQ-034 Overwrite: base=5, len=3, acc_mode=0, relu_en=0, OFIFO lanes all 7,8,9 -> SRAM addr 5,6,7 = 7,8,9; done 7 cycles after start.
REQ-035 Accumulate: mem[10] lanes=100, OFIFO lanes=-30, acc_mode=1 -> one read then write of 70 at addr 10; exactly one ofifo_rd.
REQ-036 ReLU and saturation: mem lane=32000, OFIFO lane=1000, relu_en=1 -> 32767 with PSUM_SAT_EN, 0 (wrapped negative, clamped) without.
REQ-037 Stall and wrap: base=2047, len=2, ofifo_valid low 4 cycles mid-job -> writes at 2047 then 0, no SRAM access or ofifo_rd while stalled.
REQ-038 Edge cases: len=0 -> done next cycle, no access; reset asserted in WRITE -> IDLE next edge, no write, start during busy ignored.

Source files
------------

// File: rtl/psum_accum_engine.sv
// psum_accum_engine
// Drains psum vectors from the OFIFO into the psum SRAM. Each vector either
// overwrites its SRAM slot or is added lane-by-lane to the slot's current
// contents. An optional per-lane ReLU is applied just before the write.
// Every vector takes two cycles: FETCH pops it and, when accumulating, reads
// the old value; WRITE then stores the result.
//
// Build option: define PSUM_SAT_EN to saturate the per-lane add to the signed
// psum range. When it is left undefined, the add wraps modulo 2^psum_bw.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; job fields are latched on start
// S_FETCH | waiting for an OFIFO vector; pops it and reads SRAM if acc_mode
// S_WRITE | writes f(captured [+ Q]) to addr, then advances addr/remaining
// S_DONE  | one-cycle completion pulse, then back to idle
module psum_accum_engine #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     acc_mode,
    input  logic                     relu_en,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic [addr_bw:0]         len,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    output logic                     CEN,
    output logic                     WEN,
    output logic [addr_bw-1:0]       A,
    output logic [col*psum_bw-1:0]   D,
    input  logic [col*psum_bw-1:0]   Q,
    output logic                     busy,
    output logic                     done
);

    localparam int DW = col * psum_bw;
    localparam logic [addr_bw-1:0] ADDR_ONE = {{(addr_bw-1){1'b0}}, 1'b1};
    localparam logic [addr_bw:0]   REM_ONE  = {{addr_bw{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [addr_bw-1:0]  addr_q;
    logic [addr_bw-1:0]  addr_d;
    logic [addr_bw:0]    rem_q;
    logic [addr_bw:0]    rem_d;
    logic [DW-1:0]       data_q;
    logic                acc_q;
    logic                relu_q;
    logic                busy_q;
    logic                done_q;

    logic                fetch_go;
    logic                write_go;
    logic [DW-1:0]       wr_data;

    // Per-lane result: optional add (wrapping or saturating), then optional ReLU.
    function automatic logic [psum_bw-1:0] lane_f(
        input logic [psum_bw-1:0] cap,
        input logic [psum_bw-1:0] mem,
        input logic               acc,
        input logic               relu
    );
        logic [psum_bw-1:0] r;
`ifdef PSUM_SAT_EN
        logic [psum_bw:0]   sum_w;
        sum_w = {cap[psum_bw-1], cap} + {mem[psum_bw-1], mem};
        if (!acc) begin
            r = cap;
        end else if (sum_w[psum_bw] != sum_w[psum_bw-1]) begin
            // Sign of the widened sum tells which rail was crossed.
            r = sum_w[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                               : {1'b0, {(psum_bw-1){1'b1}}};
        end else begin
            r = sum_w[psum_bw-1:0];
        end
`else
        r = acc ? (cap + mem) : cap;
`endif
        if (relu && r[psum_bw-1]) begin
            r = '0;
        end
        return r;
    endfunction

    for (genvar g = 0; g < col; g++) begin : g_lane
        assign wr_data[g*psum_bw +: psum_bw] =
            lane_f(data_q[g*psum_bw +: psum_bw], Q[g*psum_bw +: psum_bw], acc_q, relu_q);
    end

    // Address and remaining-count successors used on every WRITE.
    always_comb begin
        addr_d = addr_q + ADDR_ONE;
        rem_d  = rem_q - REM_ONE;
    end

    // Sequencer: job latch, vector capture, address walk and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            acc_q   <= 1'b0;
            relu_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q  <= acc_mode;
                        relu_q <= relu_en;
                        addr_q <= base_addr;
                        rem_q  <= len;
                        if (len != '0) begin
                            state_q <= S_FETCH;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (ofifo_valid) begin
                        data_q  <= ofifo_out;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr_q <= addr_d;
                    rem_q  <= rem_d;
                    if (rem_d != '0) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // SRAM/OFIFO strobes. Reset masks everything immediately so an aborted
    // job cannot issue an access in the cycle where reset is applied.
    always_comb begin
        fetch_go = 1'b0;
        write_go = 1'b0;
        if (!reset) begin
            fetch_go = (state_q == S_FETCH) && ofifo_valid;
            write_go = (state_q == S_WRITE);
        end
        ofifo_rd = fetch_go;
        CEN      = !((fetch_go && acc_q) || write_go);
        WEN      = !write_go;
        A        = reset ? '0 : addr_q;
        D        = write_go ? wr_data : '0;
        busy     = busy_q && !reset;
        done     = done_q && !reset;
    end

endmodule
